// File: rtl/cpu_tlb_pkg.sv
// Shared types for the fully-associative CPU TLB: request opcodes and sweep FSM states.
package cpu_tlb_pkg;

  typedef enum logic [1:0] {
    OP_LOOKUP     = 2'd0,
    OP_WRITE      = 2'd1,
    OP_INVALIDATE = 2'd2,
    OP_FLUSH      = 2'd3
  } tlb_op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } tlb_state_t;

endpackage

// File: rtl/cpu_tlb_match.sv
// Parallel enable-qualified key compare followed by a lowest-index priority encoder.
module cpu_tlb_match #(
  parameter int N     = 8,
  parameter int W     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]        en,
  input  logic [N-1:0][W-1:0] keys,
  input  logic [W-1:0]        key,
  output logic                hit,
  output logic [IDX_W-1:0]    idx
);

  logic [N-1:0] match_s;
  logic         found_s;

  // Compare every slot in parallel, then pick the lowest matching index.
  always_comb begin
    idx     = '0;
    found_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      match_s[i] = en[i] && (keys[i] == key);
    end
    for (int i = 0; i < N; i++) begin
      idx     = (match_s[i] && !found_s) ? IDX_W'(i) : idx;
      found_s = found_s | match_s[i];
    end
    hit = |match_s;
  end

endmodule

// File: rtl/cpu_tlb.sv
// Fully-associative TLB with lookup/write/invalidate/flush, round-robin replacement
// once full, and saturating hit/miss statistics.
module cpu_tlb
  import cpu_tlb_pkg::*;
#(
  parameter int ENTRIES             = 8,
  parameter int VIRTUAL_ADDR_WIDTH  = 32,
  parameter int PHYSICAL_ADDR_WIDTH = 32,
  parameter int PAGE_SIZE           = 4096,
  parameter int KEY_WIDTH           = VIRTUAL_ADDR_WIDTH - $clog2(PAGE_SIZE),
  parameter int VALUE_WIDTH         = PHYSICAL_ADDR_WIDTH - $clog2(PAGE_SIZE),
  parameter int CNT_WIDTH           = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [KEY_WIDTH-1:0]   req_key,
  input  logic [VALUE_WIDTH-1:0] req_value,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [VALUE_WIDTH-1:0] resp_value,
  output logic [CNT_WIDTH-1:0]   hit_cnt,
  output logic [CNT_WIDTH-1:0]   miss_cnt,
  output logic                   busy
);

  localparam int IDX_W = $clog2(ENTRIES);

  tlb_state_t                              state_r;
  logic                                    ready_r;
  logic                                    busy_r;
  logic [ENTRIES-1:0]                      valid_r;
  logic [ENTRIES-1:0][KEY_WIDTH-1:0]       key_r;
  logic [ENTRIES-1:0][VALUE_WIDTH-1:0]     value_r;
  logic [IDX_W-1:0]                        rr_ptr_r;
  logic [IDX_W-1:0]                        flush_idx_r;
  logic [CNT_WIDTH-1:0]                    hit_cnt_r;
  logic [CNT_WIDTH-1:0]                    miss_cnt_r;
  logic                                    resp_valid_r;
  logic                                    resp_hit_r;
  logic [VALUE_WIDTH-1:0]                  resp_value_r;

  tlb_op_t                                 op_s;
  logic                                    accept_s;
  logic                                    hit_s;
  logic [IDX_W-1:0]                        hit_idx_s;
  logic                                    free_s;
  logic [IDX_W-1:0]                        free_idx_s;
  logic [IDX_W-1:0]                        wr_idx_s;
  logic                                    write_en_s;
  logic [ENTRIES-1:0]                      invalid_s;
  logic [ENTRIES-1:0][0:0]                 zero_keys_s;

  assign op_s        = tlb_op_t'(req_op);
  assign accept_s    = req_valid && (state_r == IDLE);
  assign invalid_s   = ~valid_r;
  assign zero_keys_s = '0;
  assign write_en_s  = accept_s && (op_s == OP_WRITE) && !reset;
  // Overwrite in place on a match, otherwise fill a hole, otherwise evict the round-robin victim.
  assign wr_idx_s    = hit_s ? hit_idx_s : (free_s ? free_idx_s : rr_ptr_r);

  cpu_tlb_match #(.N(ENTRIES), .W(KEY_WIDTH)) u_key_match (
    .en   (valid_r),
    .keys (key_r),
    .key  (req_key),
    .hit  (hit_s),
    .idx  (hit_idx_s)
  );

  // The same encoder finds the lowest invalid slot: every invalid entry "matches" a zero key.
  cpu_tlb_match #(.N(ENTRIES), .W(1)) u_free_search (
    .en   (invalid_s),
    .keys (zero_keys_s),
    .key  (1'b0),
    .hit  (free_s),
    .idx  (free_idx_s)
  );

  // Control FSM: valid bits, replacement pointer, flush sweep, statistics and response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      ready_r      <= 1'b1;
      busy_r       <= 1'b0;
      valid_r      <= '0;
      rr_ptr_r     <= '0;
      flush_idx_r  <= '0;
      hit_cnt_r    <= '0;
      miss_cnt_r   <= '0;
      resp_valid_r <= 1'b0;
      resp_hit_r   <= 1'b0;
      resp_value_r <= '0;
    end else begin
      resp_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            case (op_s)
              OP_LOOKUP: begin
                resp_valid_r <= 1'b1;
                resp_hit_r   <= hit_s;
                resp_value_r <= hit_s ? value_r[hit_idx_s] : '0;
                if (hit_s) begin
                  if (hit_cnt_r != '1) hit_cnt_r <= hit_cnt_r + CNT_WIDTH'(1);
                end else begin
                  if (miss_cnt_r != '1) miss_cnt_r <= miss_cnt_r + CNT_WIDTH'(1);
                end
              end
              OP_WRITE: begin
                valid_r[wr_idx_s] <= 1'b1;
                if (!hit_s && !free_s) rr_ptr_r <= rr_ptr_r + IDX_W'(1);
              end
              OP_INVALIDATE: begin
                if (hit_s) valid_r[hit_idx_s] <= 1'b0;
              end
              OP_FLUSH: begin
                state_r     <= FLUSH;
                ready_r     <= 1'b0;
                busy_r      <= 1'b1;
                rr_ptr_r    <= '0;
                flush_idx_r <= '0;
              end
              default: ;
            endcase
          end
        end
        FLUSH: begin
          valid_r[flush_idx_r] <= 1'b0;
          flush_idx_r          <= flush_idx_r + IDX_W'(1);
          if (flush_idx_r == IDX_W'(ENTRIES - 1)) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Key/value payload: no reset needed since valid bits gate every use.
  always_ff @(posedge clk) begin
    if (write_en_s) begin
      key_r[wr_idx_s]   <= req_key;
      value_r[wr_idx_s] <= req_value;
    end
  end

  assign req_ready  = ready_r;
  assign busy       = busy_r;
  assign resp_valid = resp_valid_r;
  assign resp_hit   = resp_hit_r;
  assign resp_value = resp_value_r;
  assign hit_cnt    = hit_cnt_r;
  assign miss_cnt   = miss_cnt_r;

endmodule

// File: tb/tb_cpu_tlb.sv
// Randomized + directed bench for cpu_tlb against an associative-array style reference model.
module tb_cpu_tlb;

  localparam int ENTRIES = 8;
  localparam int KW      = 20;
  localparam int VW      = 20;
  localparam int CW      = 4;
  localparam int CMAX    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'd0;
  logic [KW-1:0] req_key = '0;
  logic [VW-1:0] req_value = '0;
  logic          resp_valid;
  logic          resp_hit;
  logic [VW-1:0] resp_value;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;
  logic          busy;

  int n_cmp = 0;
  int n_fail = 0;

  cpu_tlb #(.ENTRIES(ENTRIES), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_key(req_key), .req_value(req_value),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_value(resp_value),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: a table of translations plus a replacement pointer.
  bit            m_valid [ENTRIES];
  logic [KW-1:0] m_key   [ENTRIES];
  logic [VW-1:0] m_val   [ENTRIES];
  int            m_rr = 0;
  int            m_busy = 0;
  int            m_hit = 0;
  int            m_miss = 0;
  bit            e_rv = 1'b0;
  bit            e_hit = 1'b0;
  logic [VW-1:0] e_val = '0;
  bit            e_data_chk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int f;
    int g;
    e_data_chk = 1'b0;
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      m_rr = 0; m_busy = 0; m_hit = 0; m_miss = 0;
      e_rv = 1'b0; e_hit = 1'b0; e_val = '0; e_data_chk = 1'b1;
    end else if (m_busy > 0) begin
      m_busy--;
      e_rv = 1'b0;
    end else if (req_valid) begin
      f = -1;
      for (int i = 0; i < ENTRIES; i++) if (m_valid[i] && m_key[i] == req_key) f = i;
      e_rv = 1'b0;
      case (req_op)
        2'd0: begin
          e_rv = 1'b1;
          e_hit = (f >= 0);
          e_val = (f >= 0) ? m_val[f] : '0;
          if (f >= 0) m_hit = (m_hit < CMAX) ? m_hit + 1 : m_hit;
          else        m_miss = (m_miss < CMAX) ? m_miss + 1 : m_miss;
        end
        2'd1: begin
          if (f >= 0) m_val[f] = req_value;
          else begin
            g = -1;
            for (int i = ENTRIES - 1; i >= 0; i--) if (!m_valid[i]) g = i;
            if (g < 0) begin
              g = m_rr;
              m_rr = (m_rr + 1) % ENTRIES;
            end
            m_valid[g] = 1'b1; m_key[g] = req_key; m_val[g] = req_value;
          end
        end
        2'd2: if (f >= 0) m_valid[f] = 1'b0;
        default: begin
          for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
          m_rr = 0;
          m_busy = ENTRIES;
        end
      endcase
    end else begin
      e_rv = 1'b0;
    end
  endtask

  task automatic compare();
    chk("req_ready", 64'(req_ready), 64'(m_busy == 0));
    chk("busy", 64'(busy), 64'(m_busy != 0));
    chk("resp_valid", 64'(resp_valid), 64'(e_rv));
    if (e_rv || e_data_chk) begin
      chk("resp_hit", 64'(resp_hit), 64'(e_hit));
      chk("resp_value", 64'(resp_value), 64'(e_val));
    end
    chk("hit_cnt", 64'(hit_cnt), 64'(m_hit));
    chk("miss_cnt", 64'(miss_cnt), 64'(m_miss));
  endtask

  task automatic cyc();
    model_update();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic issue(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val);
    req_valid = 1'b1; req_op = op; req_key = key; req_value = val;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    chk("lit_reset_ready", 64'(req_ready), 64'd1);
    chk("lit_reset_busy", 64'(busy), 64'd0);
    chk("lit_reset_miss", 64'(miss_cnt), 64'd0);

    // Write then lookup.
    issue(2'd1, 20'h12, 20'hA5);
    issue(2'd0, 20'h12, 20'h0);
    chk("lit_hit", 64'(resp_hit), 64'd1);
    chk("lit_hit_value", 64'(resp_value), 64'hA5);
    chk("lit_hit_cnt", 64'(hit_cnt), 64'd1);

    // Overwrite in place.
    issue(2'd1, 20'h12, 20'h3C);
    issue(2'd0, 20'h12, 20'h0);
    chk("lit_overwrite_value", 64'(resp_value), 64'h3C);

    // Invalidate.
    issue(2'd2, 20'h12, 20'h0);
    issue(2'd0, 20'h12, 20'h0);
    chk("lit_inval_hit", 64'(resp_hit), 64'd0);
    chk("lit_inval_value", 64'(resp_value), 64'd0);
    chk("lit_inval_miss_cnt", 64'(miss_cnt), 64'd1);

    // Fill all entries, then round-robin replacement starting at entry 0.
    for (int i = 0; i < ENTRIES; i++) issue(2'd1, KW'(32'h20 + i), VW'(32'h100 + i));
    issue(2'd1, 20'h99, 20'h55);
    issue(2'd0, 20'h20, 20'h0);
    chk("lit_evict0_hit", 64'(resp_hit), 64'd0);
    chk("lit_evict0_miss_cnt", 64'(miss_cnt), 64'd2);
    issue(2'd0, 20'h99, 20'h0);
    chk("lit_new_value", 64'(resp_value), 64'h55);
    issue(2'd1, 20'h9A, 20'h66);
    issue(2'd0, 20'h21, 20'h0);
    chk("lit_evict1_hit", 64'(resp_hit), 64'd0);
    issue(2'd0, 20'h22, 20'h0);
    chk("lit_keep2_value", 64'(resp_value), 64'h102);

    // Flush sweep with a request held the whole time.
    issue(2'd3, 20'h0, 20'h0);
    chk("lit_flush_busy0", 64'(busy), 64'd1);
    req_valid = 1'b1; req_op = 2'd0; req_key = 20'h22;
    for (int i = 1; i < ENTRIES; i++) begin
      cyc();
      chk("lit_flush_ready_low", 64'(req_ready), 64'd0);
    end
    cyc();
    req_valid = 1'b0;
    chk("lit_flush_done_ready", 64'(req_ready), 64'd1);
    issue(2'd0, 20'h22, 20'h0);
    chk("lit_after_flush_hit", 64'(resp_hit), 64'd0);

    // Reset during the sweep.
    for (int i = 0; i < 4; i++) issue(2'd1, KW'(32'h40 + i), VW'(32'h200 + i));
    issue(2'd3, 20'h0, 20'h0);
    cyc();
    cyc();
    do_reset();
    chk("lit_midflush_ready", 64'(req_ready), 64'd1);
    chk("lit_midflush_busy", 64'(busy), 64'd0);
    chk("lit_midflush_hit_cnt", 64'(hit_cnt), 64'd0);
    issue(2'd0, 20'h41, 20'h0);
    chk("lit_midflush_miss", 64'(resp_hit), 64'd0);

    // Miss counter saturation.
    for (int i = 0; i < CMAX + 4; i++) issue(2'd0, KW'(32'h500 + i), 20'h0);
    chk("lit_miss_sat", 64'(miss_cnt), 64'(CMAX));
    do_reset();

    // Random traffic with a small key space to exercise replacement and collisions.
    for (int n = 0; n < 3000; n++) begin
      int r;
      reset = ($urandom_range(0, 299) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 39);
      req_op = (r < 16) ? 2'd0 : (r < 32) ? 2'd1 : (r < 38) ? 2'd2 : 2'd3;
      req_key = KW'($urandom_range(0, 11)) + 20'h300;
      req_value = VW'($urandom);
      cyc();
    end
    reset = 1'b0;
    req_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
